wb_write_arbiter: RTL and testbench

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_queue.sv | 97 +++++++++
 rtl/wb_write_arbiter.sv | 93 +++++++++
 tb/tb_wb_write_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter and its queue.
package wb_pkg;

  localparam int DEPTH_DEFAULT = 4;

  // Architectural zero register: writes to it are discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular write queue for the multi-cycle unit. Entries can be killed by
// address when a newer pipeline write overtakes them, and a lookup port
// reports the youngest live entry for a given register.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [4:0]             push_addr_i,
  input  logic [31:0]            push_data_i,
  input  logic                   pop_i,
  input  logic                   kill_i,
  input  logic [4:0]             kill_addr_i,
  input  logic [4:0]             lk_addr_i,
  output wb_entry_t              head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   lk_hit_o,
  output logic [31:0]            lk_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [DEPTH-1:0] live_q;
  logic [4:0]     addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic           push_ok;
  logic           pop_ok;
  logic [AW-1:0]  idx;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_o = '{live: live_q[rd_ptr_q], addr: addr_q[rd_ptr_q], data: data_q[rd_ptr_q]};

  // Control state; the kill only sees entries already queued, so a same-cycle push stays live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && addr_q[i] == kill_addr_i) live_q[i] <= 1'b0;
      end
      if (pop_ok) begin
        live_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        live_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage, written on enqueue only.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Youngest live match: scan oldest to youngest so later matches override earlier ones.
  always_comb begin
    lk_hit_o  = 1'b0;
    lk_data_o = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((AW+1)'(i) < count_q && live_q[idx] && addr_q[idx] == lk_addr_i &&
          lk_addr_i != REG_ZERO) begin
        lk_hit_o  = 1'b1;
        lk_data_o = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: the pipeline port always wins, the
// multi-cycle unit is buffered in wb_queue and drained on idle cycles.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_valid,
  input  logic [4:0]             s0_addr,
  input  logic [31:0]            s0_data,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [4:0]             s1_addr,
  input  logic [31:0]            s1_data,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  input  logic [4:0]             lk_addr,
  output logic                   lk_hit,
  output logic [31:0]            lk_data,
  output logic [$clog2(DEPTH):0] q_count
);

  logic      s0_wr;
  logic      q_push;
  logic      q_pop;
  logic      q_full;
  logic      q_empty;
  wb_entry_t q_head;

  logic        rf_we_d,    rf_we_q;
  logic [4:0]  rf_waddr_d, rf_waddr_q;
  logic [31:0] rf_wdata_d, rf_wdata_q;

  assign s0_wr    = s0_valid && (s0_addr != REG_ZERO);
  assign s1_ready = !q_full;
  assign q_push   = s1_valid && s1_ready && (s1_addr != REG_ZERO);
  assign q_pop    = !s0_wr && !q_empty;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_addr_i (s1_addr),
    .push_data_i (s1_data),
    .pop_i       (q_pop),
    .kill_i      (s0_wr),
    .kill_addr_i (s0_addr),
    .lk_addr_i   (lk_addr),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count),
    .lk_hit_o    (lk_hit),
    .lk_data_o   (lk_data)
  );

  // Select this cycle's write: pipeline first, else a live queue head; address/data hold otherwise.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (s0_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = s0_addr;
      rf_wdata_d = s0_data;
    end else if (q_pop && q_head.live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = q_head.addr;
      rf_wdata_d = q_head.data;
    end
  end

  // Register-file write port register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed, table-driven bench for wb_write_arbiter (DEPTH = 4).
// Each vector is driven after a falling edge and all outputs are sampled
// shortly before the following rising edge: combinational outputs reflect
// the current inputs, registered outputs reflect the previous cycle.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        s0_valid;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [2:0]  q_count;

  int n_vec = 0;
  int n_err = 0;

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .lk_addr  (lk_addr),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data),
    .q_count  (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s0v;
    logic [4:0]  s0a;
    logic [31:0] s0d;
    logic        s1v;
    logic [4:0]  s1a;
    logic [31:0] s1d;
    logic [4:0]  lk;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic [2:0]  cnt;
    logic        hit;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
    input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d, input logic [4:0] lk,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic rdy, input logic [2:0] cnt, input logic hit, input logic [31:0] ld);
    vec_t v;
    v.r = r; v.s0v = s0v; v.s0a = s0a; v.s0d = s0d;
    v.s1v = s1v; v.s1a = s1a; v.s1d = s1d; v.lk = lk;
    v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.cnt = cnt; v.hit = hit; v.ld = ld;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t got[$];

  initial begin
    rst = 1'b1; s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0; lk_addr = '0;

    //            r  s0v s0a  s0d          s1v s1a  s1d          lk    we wa     wd           rdy cnt   hit ld
    // reset state
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    // single pipeline write
    vecs.push_back(mk(0, 1, 5'd5,  32'h1234,   0, 5'd0,  32'h0,      5'd0, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd5,  32'h1234,   1, 3'd0, 0, 32'h0));
    // fill the queue while s0 is busy every cycle
    vecs.push_back(mk(0, 1, 5'd10, 32'hA0,     1, 5'd1,  32'h11,     5'd0, 0, 5'd5,  32'h1234,   1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd11, 32'hA1,     1, 5'd2,  32'h12,     5'd0, 1, 5'd10, 32'hA0,     1, 3'd1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd12, 32'hA2,     1, 5'd3,  32'h13,     5'd0, 1, 5'd11, 32'hA1,     1, 3'd2, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd13, 32'hA3,     1, 5'd4,  32'h14,     5'd2, 1, 5'd12, 32'hA2,     1, 3'd3, 1, 32'h12));
    vecs.push_back(mk(0, 1, 5'd14, 32'hA4,     1, 5'd5,  32'h15,     5'd4, 1, 5'd13, 32'hA3,     0, 3'd4, 1, 32'h14));
    // s0 stops: drain in order
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd14, 32'hA4,     0, 3'd4, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd1,  32'h11,     1, 3'd3, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd2,  32'h12,     1, 3'd2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd3,  32'h13,     1, 3'd1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd4,  32'h14,     1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 0, 5'd4,  32'h14,     1, 3'd0, 0, 32'h0));
    // queued write to r7 overtaken by s0 write to r7
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      1, 5'd7,  32'hAAAA,   5'd7, 0, 5'd4,  32'h14,     1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd7,  32'hBBBB,   0, 5'd0,  32'h0,      5'd7, 0, 5'd4,  32'h14,     1, 3'd1, 1, 32'hAAAA));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd7, 1, 5'd7,  32'hBBBB,   1, 3'd1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd7, 0, 5'd7,  32'hBBBB,   1, 3'd0, 0, 32'h0));
    // same-cycle s0 and s1 to r9: s1 is younger and survives
    vecs.push_back(mk(0, 1, 5'd9,  32'h1,      1, 5'd9,  32'h2,      5'd9, 0, 5'd7,  32'hBBBB,   1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd9, 1, 5'd9,  32'h1,      1, 3'd1, 1, 32'h2));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd9, 1, 5'd9,  32'h2,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 0, 5'd9,  32'h2,      1, 3'd0, 0, 32'h0));
    // two entries for r3: youngest wins; s1 to r0 not enqueued; s0 to r0 counts as idle
    vecs.push_back(mk(0, 1, 5'd20, 32'h55,     1, 5'd3,  32'h10,     5'd3, 0, 5'd9,  32'h2,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd21, 32'h56,     1, 5'd3,  32'h20,     5'd3, 1, 5'd20, 32'h55,     1, 3'd1, 1, 32'h10));
    vecs.push_back(mk(0, 1, 5'd22, 32'h57,     1, 5'd0,  32'h99,     5'd3, 1, 5'd21, 32'h56,     1, 3'd2, 1, 32'h20));
    vecs.push_back(mk(0, 1, 5'd0,  32'h77,     0, 5'd0,  32'h0,      5'd0, 1, 5'd22, 32'h57,     1, 3'd2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd3, 1, 5'd3,  32'h10,     1, 3'd1, 1, 32'h20));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd3, 1, 5'd3,  32'h20,     1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 0, 5'd3,  32'h20,     1, 3'd0, 0, 32'h0));
    // reset with three entries queued: nothing queued may ever be written
    vecs.push_back(mk(0, 1, 5'd25, 32'h1,      1, 5'd6,  32'h61,     5'd0, 0, 5'd3,  32'h20,     1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd26, 32'h2,      1, 5'd7,  32'h62,     5'd0, 1, 5'd25, 32'h1,      1, 3'd1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 5'd27, 32'h3,      1, 5'd8,  32'h63,     5'd0, 1, 5'd26, 32'h2,      1, 3'd2, 0, 32'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd6, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd6, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd7, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd8, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    // first s1 after reset: two-cycle latency
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      1, 5'd15, 32'hF,      5'd0, 0, 5'd0,  32'h0,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 0, 5'd0,  32'h0,      1, 3'd1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 1, 5'd15, 32'hF,      1, 3'd0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      5'd0, 0, 5'd15, 32'hF,      1, 3'd0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst      = vecs[i].r;
      s0_valid = vecs[i].s0v; s0_addr = vecs[i].s0a; s0_data = vecs[i].s0d;
      s1_valid = vecs[i].s1v; s1_addr = vecs[i].s1a; s1_data = vecs[i].s1d;
      lk_addr  = vecs[i].lk;
      #2;
      n_vec++;
      chk("rf_we",    i, 32'(rf_we),    32'(vecs[i].we));
      chk("rf_waddr", i, 32'(rf_waddr), 32'(vecs[i].wa));
      chk("rf_wdata", i, rf_wdata,      vecs[i].wd);
      chk("s1_ready", i, 32'(s1_ready), 32'(vecs[i].rdy));
      chk("q_count",  i, 32'(q_count),  32'(vecs[i].cnt));
      chk("lk_hit",   i, 32'(lk_hit),   32'(vecs[i].hit));
      chk("lk_data",  i, lk_data,       vecs[i].ld);
    end

    // Streaming s1 with s0 idle: push and pop every cycle, pointers wrap
    // several times, occupancy stays at one and writes emerge in order.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      rst = 1'b0; s0_valid = 1'b0; s0_addr = '0; s0_data = '0; lk_addr = '0;
      s1_valid = (c < 10);
      s1_addr  = (c < 10) ? 5'(16 + c) : 5'd0;
      s1_data  = (c < 10) ? 32'(32'h100 + c) : 32'h0;
      #2;
      n_vec++;
      if (rf_we) got.push_back('{a: rf_waddr, d: rf_wdata});
      if (c >= 1 && c <= 9) chk("stream q_count", c, 32'(q_count), 32'd1);
      if (c == 0 || c == 1) chk("stream rf_we early", c, 32'(rf_we), 32'd0);
    end
    chk("stream write count", 0, 32'(got.size()), 32'd10);
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      chk("stream waddr", k, 32'(got[k].a), 32'(16 + k));
      chk("stream wdata", k, got[k].d, 32'(32'h100 + k));
    end
    chk("stream drained count", 0, 32'(q_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
